// File: rtl/cdc_pulse_arbiter.sv
// rtl/cdc_pulse_arbiter.sv - round-robin sharing of one pulse-to-toggle CDC channel
// Latches request strobes, grants round-robin, issues one pulse per grant and waits for the ack toggle.
module cdc_pulse_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic               ack_tgl,
  output logic [NUM_REQ-1:0] req_pending,
  output logic [NUM_REQ-1:0] req_done,
  output logic               xfer_pulse,
  output logic [ID_W-1:0]    xfer_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic               ack_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    xfer_id_q, xfer_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               terr_q, terr_d;

  logic               ack_evt;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] cur_onehot;
  logic [NUM_REQ-1:0] clr_mask;

  assign ack_evt    = ack_tgl ^ ack_q;
  assign cur_onehot = NUM_REQ'(1) << xfer_id_q;

  // Search starts one past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld && pend_q[ID_W'((int'(last_id_q) + k) % NUM_REQ)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(last_id_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    xfer_id_d = xfer_id_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    terr_d    = 1'b0;
    clr_mask  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          xfer_id_d = grant_id;
          last_id_d = grant_id;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack in the threshold cycle takes priority over the timeout.
        if (ack_evt) begin
          done_d   = cur_onehot;
          clr_mask = cur_onehot;
          state_d  = S_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          terr_d   = 1'b1;
          clr_mask = cur_onehot;
          state_d  = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new strobe in the same cycle as the clear keeps the bit set.
  assign pend_d = (pend_q & ~clr_mask) | req_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      ack_q     <= 1'b0;
      cnt_q     <= '0;
      xfer_id_q <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      done_q    <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ack_q     <= ack_tgl;
      cnt_q     <= cnt_d;
      xfer_id_q <= xfer_id_d;
      last_id_q <= last_id_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
    end
  end

  assign req_pending = pend_q;
  assign req_done    = done_q;
  assign xfer_pulse  = (state_q == S_ISSUE);
  assign xfer_id     = xfer_id_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// tb/tb_cdc_pulse_arbiter.sv - scoreboard bench for cdc_pulse_arbiter
// Stimulus pushes expected events with their cycle; a negedge monitor pops and compares.
module tb_cdc_pulse_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int EV_XFER = 0;
  localparam int EV_DONE = 1;
  localparam int EV_TOUT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_pulse = '0;
  logic         ack_tgl = 1'b0;
  logic [N-1:0] req_pending;
  logic [N-1:0] req_done;
  logic         xfer_pulse;
  logic [1:0]   xfer_id;
  logic         busy;
  logic         timeout_err;

  cdc_pulse_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_pulse  (req_pulse),
    .ack_tgl    (ack_tgl),
    .req_pending(req_pending),
    .req_done   (req_done),
    .xfer_pulse (xfer_pulse),
    .xfer_id    (xfer_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_val", val, e.val);
      chk("event_cycle", cyc, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (xfer_pulse) see(EV_XFER, int'(xfer_id));
      if (|req_done) see(EV_DONE, int'(req_done));
      if (timeout_err) see(EV_TOUT, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic pulse_at(input int t, input logic [N-1:0] m);
    wait_until(t);
    req_pulse = m;
    tick();
    req_pulse = '0;
  endtask

  task automatic flip_at(input int t);
    wait_until(t);
    ack_tgl = ~ack_tgl;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pending"}, int'(req_pending), 0);
    chk({tag, "_done"}, int'(req_done), 0);
    chk({tag, "_xfer_pulse"}, int'(xfer_pulse), 0);
    chk({tag, "_xfer_id"}, int'(xfer_id), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_timeout"}, int'(timeout_err), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    tick();
    do_reset();

    // Single request from requester 2, ack 5 cycles after the pulse.
    c = cyc;
    push(EV_XFER, 2, c + 2);
    push(EV_DONE, 4, c + 8);
    pulse_at(c, 4'b0100);
    chk("single_pending_set", int'(req_pending), 4);
    flip_at(c + 7);
    wait_until(c + 8);
    chk("single_pending_clr", int'(req_pending), 0);
    chk("single_busy_after_done", int'(busy), 0);
    wait_until(c + 12);
    chk("single_drained", exp_q.size(), 0);

    // Round robin from reset: 0,1,2,3 then 0,3.
    do_reset();
    c = cyc;
    for (int j = 0; j < 4; j++) begin
      push(EV_XFER, j, c + 2 + 5 * j);
      push(EV_DONE, 1 << j, c + 6 + 5 * j);
    end
    pulse_at(c, 4'b1111);
    for (int j = 0; j < 4; j++) flip_at(c + 5 + 5 * j);
    wait_until(c + 25);
    chk("rr4_drained", exp_q.size(), 0);

    c = cyc;
    push(EV_XFER, 0, c + 2);
    push(EV_DONE, 1, c + 6);
    push(EV_XFER, 3, c + 7);
    push(EV_DONE, 8, c + 11);
    pulse_at(c, 4'b1001);
    flip_at(c + 5);
    flip_at(c + 10);
    wait_until(c + 15);
    chk("rr2_drained", exp_q.size(), 0);

    // Coalescing, then a re-request in the clearing cycle: two transfers.
    c = cyc;
    push(EV_XFER, 1, c + 2);
    push(EV_DONE, 2, c + 8);
    push(EV_XFER, 1, c + 9);
    push(EV_DONE, 2, c + 13);
    pulse_at(c, 4'b0010);
    pulse_at(c + 1, 4'b0010);
    pulse_at(c + 3, 4'b0010);
    pulse_at(c + 4, 4'b0010);
    flip_at(c + 7);
    pulse_at(c + 7, 4'b0010);
    chk("setwins_pending", int'(req_pending), 2);
    flip_at(c + 12);
    wait_until(c + 17);
    chk("coalesce_drained", exp_q.size(), 0);

    // Timeout with no ack, then a stale ack in IDLE is ignored.
    c = cyc;
    push(EV_XFER, 2, c + 2);
    push(EV_TOUT, 0, c + 11);
    pulse_at(c, 4'b0100);
    wait_until(c + 11);
    chk("timeout_pending_clr", int'(req_pending), 0);
    chk("timeout_busy", int'(busy), 0);
    flip_at(c + 14);
    wait_until(c + 20);
    chk("timeout_drained", exp_q.size(), 0);

    // Ack lands in the 8th WAIT cycle: completes, no timeout.
    c = cyc;
    push(EV_XFER, 3, c + 2);
    push(EV_DONE, 8, c + 11);
    pulse_at(c, 4'b1000);
    flip_at(c + 10);
    wait_until(c + 16);
    chk("threshold_drained", exp_q.size(), 0);

    // Reset during WAIT with another request pending.
    c = cyc;
    push(EV_XFER, 0, c + 2);
    pulse_at(c, 4'b0011);
    wait_until(c + 4);
    chk("midwait_busy", int'(busy), 1);
    do_reset();
    chk("midwait_drained", exp_q.size(), 0);

    c = cyc;
    push(EV_XFER, 0, c + 2);
    push(EV_DONE, 1, c + 6);
    pulse_at(c, 4'b0001);
    flip_at(c + 5);
    wait_until(c + 10);
    chk("final_drained", exp_q.size(), 0);
    chk("final_pending", int'(req_pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_arbiter.md
# cdc_pulse_arbiter

Source-domain controller that shares one pulse-to-toggle CDC channel between `NUM_REQ` requesters. It latches request pulses as sticky pending bits and grants them round-robin. For each grant it issues a single-cycle pulse with a requester ID to the channel's toggle encoder, then waits for the returned acknowledge toggle before the next grant. A timeout recovers from lost acknowledges. The block sits in the sending clock domain, in front of the pulse-to-toggle cell and its synchronizer pair.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT_CYCLES`, default 255: WAIT cycles allowed before abort, 1..65535. 0 disables the timeout.
- `ID_W`, derived as `$clog2(NUM_REQ)`: width of the requester ID. Not overridable.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_pulse`  in  NUM_REQ  one-cycle request strobes, one bit per requester.
- `ack_tgl`  in  1  acknowledge toggle from the destination domain, already synchronized to `clk`.
- `req_pending`  out  NUM_REQ  registered sticky pending bits.
- `req_done`  out  NUM_REQ  one-cycle completion strobe per requester.
- `xfer_pulse`  out  1  one-cycle pulse that drives the toggle encoder's `pulse` input.
- `xfer_id`  out  ID_W  ID of the granted requester; registered and stable from ISSUE through WAIT.
- `busy`  out  1  high in ISSUE and WAIT.
- `timeout_err`  out  1  one-cycle strobe when a transfer is aborted.

## Operation
- **Pending bits**
  - `req_pulse[i]` sets `pending[i]` on the next edge.
  - A pulse while `pending[i]` is already set is coalesced. It does not add a second transfer.
  - `pending[i]` clears on completion or timeout of its own transfer.
  - If a set and a clear for the same bit occur in the same cycle, the set wins.
- **Round-robin pointer**
  - `last_id` holds the last granted ID and resets to `NUM_REQ-1`, so requester 0 has first priority.
  - The search starts at `last_id+1` and wraps modulo `NUM_REQ`.
- **Acknowledge detection**
  - `ack_q` is a register of `ack_tgl`, reset to 0.
  - An acknowledge event is `ack_tgl ^ ack_q`, evaluated every cycle.
  - Events outside WAIT are discarded, for example a stale ack after a timeout.
- **FSM**
  - IDLE: if any pending bit is set, latch the winner into `xfer_id` and `last_id`, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `xfer_pulse=1` for exactly this cycle. Clear the timeout counter, then go to WAIT.
  - WAIT, acknowledge event: `req_done[xfer_id]=1` on the next cycle, clear `pending[xfer_id]`, go to IDLE.
  - WAIT, no event and counter equals `TIMEOUT_CYCLES-1` (timeout enabled): `timeout_err=1` on the next cycle, clear `pending[xfer_id]`, no `req_done`, go to IDLE.
  - WAIT, otherwise: increment the counter.
- **Counter**
  - Width is `$clog2(TIMEOUT_CYCLES+1)` and the counter never wraps.
  - An acknowledge event in the timeout-threshold cycle wins: it completes the transfer and no timeout is raised.
- **Out-of-range IDs**: IDs at or above `NUM_REQ` are never generated.

## Timing
- **Reset values**: all outputs are 0 and the state is IDLE. `pending`, `ack_q` and the counter are 0, and `last_id` is `NUM_REQ-1`.
- **Reset mid-transfer**: asserting `rst_n` low during a transfer aborts it immediately and asynchronously. No `req_done` and no `timeout_err` are produced.
- **Request latency**: `req_pulse[i]` in cycle 0 gives `req_pending[i]` in cycle 1, the IDLE grant in cycle 1, and `xfer_pulse` with valid `xfer_id` in cycle 2.
- **Completion latency**: an acknowledge event seen in cycle k gives `req_done` and `busy=0` in cycle k+1. If more work is pending, the next `xfer_pulse` is in cycle k+2.
- **Pulse spacing**: `xfer_pulse` is never high in two consecutive cycles. At most one transfer is outstanding.
- **Strobes**: `req_done`, `timeout_err` and `xfer_pulse` are each one cycle wide. `req_done` is one-hot or zero.

## Test plan
- **Single request**: with `NUM_REQ=4`, pulse `req_pulse=4'b0100` in cycle 0, and flip `ack_tgl` 5 cycles after `xfer_pulse`.
  - Expect `xfer_pulse` in cycle 2 with `xfer_id=2`.
  - Expect `req_done=4'b0100` one cycle after the flip, and `req_pending` cleared.
- **Round robin**: pulse `req_pulse=4'b1111` once, and acknowledge each transfer 3 cycles after its pulse.
  - Expect grant order 0,1,2,3 with exactly four `xfer_pulse`.
  - Then pulse `4'b1001` and expect grant order 0,3.
- **Coalescing and set-wins**: pulse `req_pulse[1]` three times while it is pending, then pulse it again in the same cycle as its `req_done`.
  - Expect exactly 2 transfers for requester 1.
- **Timeout**: with `TIMEOUT_CYCLES=8`, never flip `ack_tgl`.
  - Expect `timeout_err` 9 cycles after `xfer_pulse`, no `req_done`, and the pending bit cleared.
  - A later flip of `ack_tgl` in IDLE produces no `req_done`.
- **Ack at threshold**: flip `ack_tgl` so the event lands in the 8th WAIT cycle.
  - Expect `req_done` and no `timeout_err`.
- **Reset mid-WAIT**: assert `rst_n` low during WAIT with other requests pending.
  - Expect all outputs 0 immediately and `req_pending=0`.
  - After release, a `req_pulse[0]` is granted normally in cycle 2.
